control_unit: RTL
=================

# control_unit

Hardwired Moore-style control sequencer for the mini CPU `data_path`. It replaces bench-driven control strobes. It steps through fetch (T0–T2) and per-opcode execute states (T3–T7), and drives every datapath enable, the bus-source selects and the 5-bit ALU `op`. It stalls on a memory ready handshake and stops on `halt`.

## Interface
- `OPW`, 5: opcode/ALU op width; the opcode is `irOut[31:27]`.
- `Clock` input 1: sole clock; all state changes on the rising edge.
- `clear` input 1: asynchronous, active-low reset.
- `irOut` input 32: IR contents from `data_path`.
- `branchCompare` input 1: CON flip-flop output.
- `mem_ready` input 1: memory has completed the current `Read` or `Write` this cycle.
- Outputs, each 1 bit:
  - Bus sources: `PCout`, `Zhighout`, `Zlowout`, `MDRout`, `HIout`, `LOout`, `InPortout`, `Cout`, `BAout`, `Rout`.
  - Register select: `Gra`, `Grb`, `Grc`, `Rin`.
  - Load enables: `PCin`, `IncPC`, `MARin`, `MDRin`, `IRin`, `Yin`, `HIin`, `LOin`, `ZHighin`, `Zlowin`, `CONin`, `OutPortin`.
  - Memory: `Read`, `Write`.
- `op` output 5: ALU operation code.
- `run` output 1: high while the sequencer is executing; low in reset and in HALT.

## Operation
- State register: `RESET`, `T0`…`T7`, `HALT`.
- Outputs are a combinational decode of the state register and `irOut[31:27]`. The datapath samples them on the next rising edge. Every output not listed for a state is 0, and `op` is 0 unless listed.
- Opcodes:
  - `ld` 00000, `ldi` 00001, `st` 00010.
  - `add` 00011, `sub` 00100, `and` 00101, `or` 00110, `ror` 00111, `rol` 01000, `shr` 01001, `shra` 01010, `shl` 01011.
  - `addi` 01100, `andi` 01101, `ori` 01110.
  - `div` 01111, `mul` 10000, `neg` 10001, `not` 10010.
  - `br` 10011, `jr` 10101, `in` 10110, `out` 10111, `mfhi` 11000, `mflo` 11001, `nop` 11010, `halt` 11011.
  - Any other code executes as `nop`.
- "Z" below means `ZHighin` and `Zlowin` together.
- Fetch:
  - T0: `PCout`, `MARin`, `IncPC`, Z.
  - T1: `Zlowout`, `PCin`, `Read`, `MDRin`.
  - T2: `MDRout`, `IRin`.
- R-type (`add` through `shl`):
  - T3: `Grb`, `Rout`, `Yin`.
  - T4: `Grc`, `Rout`, `op`=opcode, Z.
  - T5: `Zlowout`, `Gra`, `Rin`; then T0.
- Immediate (`addi`, `andi`, `ori`):
  - T3: `Grb`, `Rout`, `Yin`.
  - T4: `Cout`, `op`=00011/00101/00110, Z.
  - T5: as R-type.
- Address computation for `ld`, `ldi`, `st`:
  - T3: `Grb`, `BAout`, `Yin`.
  - T4: `Cout`, `op`=00011, Z.
- `ldi` T5: `Zlowout`, `Gra`, `Rin`; then T0.
- `ld`:
  - T5: `Zlowout`, `MARin`.
  - T6: `Read`, `MDRin`.
  - T7: `MDRout`, `Gra`, `Rin`; then T0.
- `st`:
  - T5: `Zlowout`, `MARin`.
  - T6: `Gra`, `Rout`, `MDRin`.
  - T7: `Write`; then T0.
- `mul`, `div`:
  - T3: `Gra`, `Rout`, `Yin`.
  - T4: `Grb`, `Rout`, `op`=opcode, Z.
  - T5: `Zlowout`, `LOin`.
  - T6: `Zhighout`, `HIin`; then T0.
- `neg`, `not`:
  - T3: `Grb`, `Rout`, `op`=opcode, Z.
  - T4: `Zlowout`, `Gra`, `Rin`; then T0.
- `br`:
  - T3: `Gra`, `Rout`, `CONin`.
  - T4: `PCout`, `Yin`.
  - T5: `Cout`, `op`=00011, Z.
  - T6: `Zlowout` and `PCin` only if `branchCompare`=1; then T0.
- Single-step opcodes, each completing in T3 and returning to T0:
  - `jr`: `Gra`, `Rout`, `PCin`.
  - `in`: `InPortout`, `Gra`, `Rin`.
  - `out`: `Gra`, `Rout`, `OutPortin`.
  - `mfhi`: `HIout`, `Gra`, `Rin`.
  - `mflo`: `LOout`, `Gra`, `Rin`.
  - `nop`: no outputs.
- `halt`: T3 goes to HALT. HALT holds with all outputs 0 until `clear` is asserted.

## Timing
- `clear`=0 forces `RESET` immediately. All outputs read 0, `op`=0 and `run`=0 within the same cycle, regardless of state.
- The first rising edge with `clear`=1 moves RESET to T0, and `run` becomes 1. `run` stays 1 in T0–T7 and is 0 in HALT.
- Memory wait states:
  - T1 (fetch), `ld` T6 and `st` T7 hold their state and all their outputs while `mem_ready`=0.
  - They advance on the edge where `mem_ready`=1.
  - Repeated `PCin` during a T1 stall reloads the same Z value, which is harmless.
- Cycle counts with zero-wait memory (`mem_ready` tied 1), measured from T0 to the next T0:
  - Single-step opcodes: 4.
  - `neg`/`not`: 5.
  - R-type, immediate, `ldi`: 6.
  - `mul`/`div`, `br`: 7.
  - `ld`, `st`: 8.
  - Each wait cycle adds 1.
- Decode uses the `irOut` value sampled in T3 onward, i.e. after the IR load at the end of T2.
- `branchCompare` is sampled only in `br` T6; CON was loaded at the end of T3.
- `Read` and `Write` are never asserted in the same cycle, and are never asserted in RESET or HALT.

## Test plan
- Reset mid-operation: assert `clear`=0 during `ld` T6 with `Read`=1. `Read`, `MDRin` and `run` go to 0 without a clock edge. After release the sequencer reaches T0 on the next edge and `PCout`=1.
- Fetch with 2 wait cycles (`mem_ready`=0,0,1) on `add` IR 0x1A218000: T1 lasts 3 cycles. T4 drives `op`=00011 with `Grc`. T5 drives `Rin` with `Gra`. Total 8 cycles T0→T0.
- `st` with zero-wait memory, IR 0x10800065: T4 `op`=00011 with `Cout`. T5 `MARin`. T6 `Rout`+`MDRin`. T7 `Write`=1 for exactly 1 cycle. 8 cycles total.
- `br` with `branchCompare`=0, then a second `br` with `branchCompare`=1: `PCin` stays 0 in T6 for the first and is 1 in T6 for the second. Both take 7 cycles.
- `mul` IR 0x81180000: T5 `Zlowout`+`LOin`, T6 `Zhighout`+`HIin`, then T0.
- `halt` 0xD8000000 followed by unknown opcode 0xF8000000 on reload: HALT holds with `run`=0 for 20 cycles and all outputs 0. After reset, the unknown opcode returns to T0 after T3 as `nop`.

Source files
------------

// File: rtl/control_unit_if.sv
// control_unit_if: groups the sequencer's datapath-facing signals.
//   irOut, branchCompare, mem_ready : status from data_path / memory
//   PCout .. Write                  : 1-bit control strobes to data_path
//   op                              : ALU operation code (OPW bits)
//   run                             : high while the sequencer executes
// modport master: the control unit; modport slave: the datapath side.
interface control_unit_if #(parameter int OPW = 5);
  logic [31:0]    irOut;
  logic           branchCompare;
  logic           mem_ready;

  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
  logic Gra, Grb, Grc, Rin;
  logic PCin, IncPC, MARin, MDRin, IRin, Yin, HIin, LOin, ZHighin, Zlowin, CONin, OutPortin;
  logic Read, Write;
  logic [OPW-1:0] op;
  logic           run;

  modport master (
    input  irOut, branchCompare, mem_ready,
    output PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
           Gra, Grb, Grc, Rin,
           PCin, IncPC, MARin, MDRin, IRin, Yin, HIin, LOin, ZHighin, Zlowin, CONin, OutPortin,
           Read, Write, op, run
  );

  modport slave (
    output irOut, branchCompare, mem_ready,
    input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
           Gra, Grb, Grc, Rin,
           PCin, IncPC, MARin, MDRin, IRin, Yin, HIin, LOin, ZHighin, Zlowin, CONin, OutPortin,
           Read, Write, op, run
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: hardwired Moore control sequencer for the mini CPU data_path.
// Steps through fetch (T0-T2) and per-opcode execute states (T3-T7), stalls
// on mem_ready during memory cycles and parks in HALT on the halt opcode.
// Ports:
//   Clock : rising-edge clock
//   clear : asynchronous active-low reset (forces RESET, all outputs 0)
//   bus   : control_unit_if.master (irOut/branchCompare/mem_ready in,
//           control strobes, op and run out)
module control_unit #(
  parameter int OPW = 5
) (
  input  logic            Clock,
  input  logic            clear,
  control_unit_if.master  bus
);

  typedef enum logic [3:0] {
    RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  typedef enum logic [4:0] {
    OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
    OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
    OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000,
    OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011,
    OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110,
    OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10101,
    OP_IN   = 5'b10110, OP_OUT  = 5'b10111, OP_MFHI = 5'b11000,
    OP_MFLO = 5'b11001, OP_NOP  = 5'b11010, OP_HALT = 5'b11011
  } opcode_t;

  state_t         state, next_state;
  logic [OPW-1:0] opc;
  logic [OPW-1:0] imm_op;
  logic           is_rtype, is_imm, is_addr, is_muldiv, is_negnot, is_br;
  logic           unused_ir;

  assign opc       = bus.irOut[31:32-OPW];
  assign unused_ir = ^bus.irOut[31-OPW:0];

  assign is_rtype  = (opc >= OP_ADD) && (opc <= OP_SHL);
  assign is_imm    = (opc >= OP_ADDI) && (opc <= OP_ORI);
  assign is_addr   = (opc == OP_LD) || (opc == OP_LDI) || (opc == OP_ST);
  assign is_muldiv = (opc == OP_MUL) || (opc == OP_DIV);
  assign is_negnot = (opc == OP_NEG) || (opc == OP_NOT);
  assign is_br     = (opc == OP_BR);

  // Immediate forms reuse the ALU code of their register counterpart.
  always_comb begin
    imm_op = OP_ADD;
    if (opc == OP_ANDI) imm_op = OP_AND;
    else if (opc == OP_ORI) imm_op = OP_OR;
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) state <= RESET;
    else        state <= next_state;
  end

  always_comb begin
    next_state    = state;
    bus.PCout     = 1'b0; bus.Zhighout = 1'b0; bus.Zlowout   = 1'b0;
    bus.MDRout    = 1'b0; bus.HIout    = 1'b0; bus.LOout     = 1'b0;
    bus.InPortout = 1'b0; bus.Cout     = 1'b0; bus.BAout     = 1'b0;
    bus.Rout      = 1'b0;
    bus.Gra       = 1'b0; bus.Grb      = 1'b0; bus.Grc       = 1'b0;
    bus.Rin       = 1'b0;
    bus.PCin      = 1'b0; bus.IncPC    = 1'b0; bus.MARin     = 1'b0;
    bus.MDRin     = 1'b0; bus.IRin     = 1'b0; bus.Yin       = 1'b0;
    bus.HIin      = 1'b0; bus.LOin     = 1'b0; bus.ZHighin   = 1'b0;
    bus.Zlowin    = 1'b0; bus.CONin    = 1'b0; bus.OutPortin = 1'b0;
    bus.Read      = 1'b0; bus.Write    = 1'b0;
    bus.op        = '0;
    bus.run       = (state != RESET) && (state != HALT);

    case (state)
      RESET: next_state = T0;

      T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1;
        bus.ZHighin = 1'b1; bus.Zlowin = 1'b1;
        next_state = T1;
      end

      T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
        if (bus.mem_ready) next_state = T2;
      end

      T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
        next_state = T3;
      end

      T3: begin
        next_state = T4;
        if (is_rtype || is_imm) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (is_addr) begin
          bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
        end else if (is_muldiv) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (is_negnot) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.op = opc;
          bus.ZHighin = 1'b1; bus.Zlowin = 1'b1;
        end else if (is_br) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1;
        end else begin
          // Single-step opcodes; unknown codes fall through as nop.
          next_state = T0;
          case (opc)
            OP_JR:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
            OP_IN:   begin bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            OP_OUT:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPortin = 1'b1; end
            OP_MFHI: begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            OP_MFLO: begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            OP_HALT: next_state = HALT;
            default: ;
          endcase
        end
      end

      T4: begin
        next_state = T5;
        if (is_rtype) begin
          bus.Grc = 1'b1; bus.Rout = 1'b1; bus.op = opc;
          bus.ZHighin = 1'b1; bus.Zlowin = 1'b1;
        end else if (is_imm) begin
          bus.Cout = 1'b1; bus.op = imm_op;
          bus.ZHighin = 1'b1; bus.Zlowin = 1'b1;
        end else if (is_addr) begin
          bus.Cout = 1'b1; bus.op = OP_ADD;
          bus.ZHighin = 1'b1; bus.Zlowin = 1'b1;
        end else if (is_muldiv) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.op = opc;
          bus.ZHighin = 1'b1; bus.Zlowin = 1'b1;
        end else if (is_negnot) begin
          bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          next_state = T0;
        end else if (is_br) begin
          bus.PCout = 1'b1; bus.Yin = 1'b1;
        end else begin
          next_state = T0;
        end
      end

      T5: begin
        next_state = T6;
        if (is_rtype || is_imm || opc == OP_LDI) begin
          bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          next_state = T0;
        end else if (opc == OP_LD || opc == OP_ST) begin
          bus.Zlowout = 1'b1; bus.MARin = 1'b1;
        end else if (is_muldiv) begin
          bus.Zlowout = 1'b1; bus.LOin = 1'b1;
        end else if (is_br) begin
          bus.Cout = 1'b1; bus.op = OP_ADD;
          bus.ZHighin = 1'b1; bus.Zlowin = 1'b1;
        end else begin
          next_state = T0;
        end
      end

      T6: begin
        next_state = T0;
        if (opc == OP_LD) begin
          bus.Read = 1'b1; bus.MDRin = 1'b1;
          next_state = bus.mem_ready ? T7 : T6;
        end else if (opc == OP_ST) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
          next_state = T7;
        end else if (is_muldiv) begin
          bus.Zhighout = 1'b1; bus.HIin = 1'b1;
        end else if (is_br) begin
          bus.Zlowout = bus.branchCompare;
          bus.PCin    = bus.branchCompare;
        end
      end

      T7: begin
        next_state = T0;
        if (opc == OP_LD) begin
          bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (opc == OP_ST) begin
          bus.Write = 1'b1;
          if (!bus.mem_ready) next_state = T7;
        end
      end

      HALT: next_state = HALT;

      default: next_state = RESET;
    endcase
  end

endmodule
